// File: rtl/zx_ram_arbiter_pkg.sv
// Shared types for the SDRAM byte-port arbiter slice.
// Arbiter FSM states, requester ids and default address width.
package zx_mem_pkg;

   localparam int ZX_AW = 25;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ACCESS,
      ARB_DONE
   } arb_state_t;

   typedef enum logic [1:0] {
      ID_DMA,
      ID_TAPE,
      ID_CPU
   } arb_id_t;

endpackage

// File: rtl/zx_ram_arbiter_if.sv
// Requester and SDRAM port bundle around zx_ram_arbiter.
// slave = arbiter side, master = requesters/sram side.
interface zx_ram_arbiter_if #(
   parameter int AW = 25
);
   logic          dma_req;
   logic          dma_we;
   logic [AW-1:0] dma_addr;
   logic [7:0]    dma_din;
   logic          dma_ack;
   logic          tape_req;
   logic [AW-1:0] tape_addr;
   logic          tape_ack;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_din;
   logic          cpu_ack;
   logic [7:0]    rdata;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din;
   logic          mem_we;
   logic          mem_rd;
   logic [7:0]    mem_dout;
   logic          busy;

   modport slave (
      input  dma_req, dma_we, dma_addr, dma_din,
      input  tape_req, tape_addr,
      input  cpu_req, cpu_we, cpu_addr, cpu_din,
      input  mem_dout,
      output dma_ack, tape_ack, cpu_ack, rdata,
      output mem_addr, mem_din, mem_we, mem_rd, busy
   );

   modport master (
      output dma_req, dma_we, dma_addr, dma_din,
      output tape_req, tape_addr,
      output cpu_req, cpu_we, cpu_addr, cpu_din,
      output mem_dout,
      input  dma_ack, tape_ack, cpu_ack, rdata,
      input  mem_addr, mem_din, mem_we, mem_rd, busy
   );
endinterface

// File: rtl/zx_ram_arbiter_pick.sv
// Combinational winner select: DMA > tape > CPU,
// except CPU beats tape once the starvation limit is hit.
module zx_arb_pick
   import zx_mem_pkg::*;
(
   input  logic [2:0] reqs_i,
   input  logic       starve_hit_i,
   output logic [2:0] gnt_o
);

   logic dma_w;
   logic tape_w;
   logic cpu_w;

   assign dma_w  = reqs_i[ID_DMA];
   assign tape_w = !dma_w && reqs_i[ID_TAPE]
                 && !(reqs_i[ID_CPU] && starve_hit_i);
   assign cpu_w  = !dma_w && reqs_i[ID_CPU]
                 && (!reqs_i[ID_TAPE] || starve_hit_i);

   always_comb begin
      gnt_o = '0;
      unique case (1'b1)
         dma_w:   gnt_o[ID_DMA]  = 1'b1;
         tape_w:  gnt_o[ID_TAPE] = 1'b1;
         cpu_w:   gnt_o[ID_CPU]  = 1'b1;
         default: gnt_o = '0;
      endcase
   end

endmodule

// File: rtl/zx_ram_arbiter.sv
// Shared SDRAM byte-port sequencer for loader DMA, tape and CPU.
// ZX_RAM_ARB_STATS_EN adds saturating per-requester grant counters.
module zx_ram_arbiter
   import zx_mem_pkg::*;
#(
   parameter int AW             = ZX_AW,
   parameter int ACCESS_CYCLES  = 4,
   parameter int CPU_STARVE_MAX = 2
) (
   input  logic             clk_sys,
   input  logic             cold_reset,
   zx_ram_arbiter_if.slave  bus
`ifdef ZX_RAM_ARB_STATS_EN
   ,
   output logic [15:0]      stat_dma,
   output logic [15:0]      stat_tape,
   output logic [15:0]      stat_cpu
`endif
);

   localparam int CW = $clog2(ACCESS_CYCLES);
   localparam int SW = (CPU_STARVE_MAX < 2) ? 1
                     : $clog2(CPU_STARVE_MAX + 1);

   arb_state_t    state_q, state_d;
   arb_id_t       id_q, id_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    din_q, din_d;
   logic          we_q, we_d;
   logic [7:0]    rdata_q, rdata_d;

   logic [2:0]    reqs;
   logic [2:0]    gnt;
   logic          starve_hit;
   logic          grant_fire;

   assign reqs[ID_DMA]  = bus.dma_req;
   assign reqs[ID_TAPE] = bus.tape_req;
   assign reqs[ID_CPU]  = bus.cpu_req;
   assign starve_hit    = (starve_q == SW'(CPU_STARVE_MAX));
   assign grant_fire    = (state_q == ARB_IDLE) && (|gnt);

   zx_arb_pick u_pick (
      .reqs_i       (reqs),
      .starve_hit_i (starve_hit),
      .gnt_o        (gnt)
   );

   always_ff @(posedge clk_sys or posedge cold_reset) begin
      if (cold_reset) begin
         state_q  <= ARB_IDLE;
         id_q     <= ID_DMA;
         cnt_q    <= '0;
         starve_q <= '0;
         addr_q   <= '0;
         din_q    <= '0;
         we_q     <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         we_q     <= we_d;
         rdata_q  <= rdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      cnt_d    = cnt_q;
      starve_d = starve_q;
      addr_d   = addr_q;
      din_d    = din_q;
      we_d     = we_q;
      rdata_d  = rdata_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (|gnt) begin
               state_d = ARB_ACCESS;
               cnt_d   = '0;
               unique case (1'b1)
                  gnt[ID_DMA]: begin
                     id_d   = ID_DMA;
                     addr_d = bus.dma_addr;
                     din_d  = bus.dma_din;
                     we_d   = bus.dma_we;
                  end
                  gnt[ID_TAPE]: begin
                     id_d   = ID_TAPE;
                     addr_d = bus.tape_addr;
                     din_d  = '0;
                     we_d   = 1'b0;
                  end
                  gnt[ID_CPU]: begin
                     id_d   = ID_CPU;
                     addr_d = bus.cpu_addr;
                     din_d  = bus.cpu_din;
                     we_d   = bus.cpu_we;
                  end
                  default: ;
               endcase
               // tape wins with CPU waiting: count toward the limit
               if (gnt[ID_TAPE] && bus.cpu_req && !starve_hit)
                  starve_d = starve_q + 1'b1;
               if (gnt[ID_CPU])
                  starve_d = '0;
            end
         end
         ARB_ACCESS: begin
            if (cnt_q == CW'(ACCESS_CYCLES - 1)) begin
               state_d = ARB_DONE;
               if (!we_q)
                  rdata_d = bus.mem_dout;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ARB_DONE: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   assign bus.busy     = (state_q != ARB_IDLE);
   assign bus.mem_we   = (state_q == ARB_ACCESS) && we_q;
   assign bus.mem_rd   = (state_q == ARB_ACCESS) && !we_q;
   assign bus.mem_addr = addr_q;
   assign bus.mem_din  = din_q;
   assign bus.rdata    = rdata_q;
   assign bus.dma_ack  = (state_q == ARB_DONE) && (id_q == ID_DMA);
   assign bus.tape_ack = (state_q == ARB_DONE) && (id_q == ID_TAPE);
   assign bus.cpu_ack  = (state_q == ARB_DONE) && (id_q == ID_CPU);

`ifdef ZX_RAM_ARB_STATS_EN
   logic [15:0] st_q [3];
   logic [15:0] st_d [3];

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         st_d[i] = st_q[i];
         if (grant_fire && gnt[i] && st_q[i] != 16'hFFFF)
            st_d[i] = st_q[i] + 16'd1;
      end
   end

   always_ff @(posedge clk_sys or posedge cold_reset) begin
      if (cold_reset) begin
         for (int i = 0; i < 3; i++) st_q[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) st_q[i] <= st_d[i];
      end
   end

   assign stat_dma  = st_q[ID_DMA];
   assign stat_tape = st_q[ID_TAPE];
   assign stat_cpu  = st_q[ID_CPU];
`else
   logic unused_fire;
   assign unused_fire = grant_fire;
`endif

endmodule
